// File: rtl/reg_file_np.sv
// rtl/reg_file_np.sv - multi-port register file with byte enables, zero register and write bypass

module reg_file_np #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             CE,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH/8-1:0] BE,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_cond;
  logic             wr_commit;
  logic [WIDTH-1:0] merged;

  // Merge write data into the currently stored word, byte by byte.
  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

  // Resolve one read port: zero register first, then bypass, then storage.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]    ra,
    input logic [WIDTH-1:0] stored,
    input logic [WIDTH-1:0] bypass_word,
    input logic             wr_active,
    input logic [AW-1:0]    wa
  );
    logic [WIDTH-1:0] res;
    if ((ZERO_REG != 0) && (ra == '0)) begin
      res = '0;
    end else if ((BYPASS != 0) && wr_active && (ra == wa)) begin
      res = bypass_word;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Write qualification and the merged word that a commit would store.
  always_comb begin
    wr_cond   = CLR && CE && WE;
    wr_commit = wr_cond && !((ZERO_REG != 0) && (WA == '0));
    merged    = merge_bytes(mem_q[WA], WD, BE);
  end

  // Next-state for the storage array: only the addressed word may change.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_commit) begin
      mem_d[WA] = merged;
    end
  end

  // Storage update; active-low synchronous clear overrides CE and WE.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!CLR) mem_q[i] <= '0;
      else      mem_q[i] <= mem_d[i];
    end
  end

  // Two independent combinational read ports.
  always_comb begin
    RD1 = read_port(RA1, mem_q[RA1], merged, wr_cond, WA);
    RD2 = read_port(RA2, mem_q[RA2], merged, wr_cond, WA);
  end

endmodule

// File: tb/tb_reg_file_np.sv
// tb/tb_reg_file_np.sv - directed self-checking bench for reg_file_np (bypass and no-bypass builds)

module tb_reg_file_np;

  logic        clk;
  logic        CLR;
  logic        CE;
  logic        WE;
  logic [2:0]  WA;
  logic [1:0]  BE;
  logic [15:0] WD;
  logic [2:0]  RA1;
  logic [2:0]  RA2;
  logic [15:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int checks;
  int failures;

  reg_file_np #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .CLR(CLR), .CE(CE), .WE(WE), .WA(WA), .BE(BE), .WD(WD),
    .RA1(RA1), .RA2(RA2), .RD1(rd1_b), .RD2(rd2_b)
  );

  reg_file_np #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .CLR(CLR), .CE(CE), .WE(WE), .WA(WA), .BE(BE), .WD(WD),
    .RA1(RA1), .RA2(RA2), .RD1(rd1_n), .RD2(rd2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    WE = 1'b1; WA = a; WD = d; BE = be;
    tick();
    WE = 1'b0;
    settle();
  endtask

  task automatic rd_both(input logic [2:0] a1, input logic [2:0] a2);
    RA1 = a1; RA2 = a2;
    settle();
  endtask

  initial begin
    checks = 0; failures = 0;
    CLR = 1'b0; CE = 1'b1; WE = 1'b0; WA = '0; BE = 2'b11; WD = '0; RA1 = '0; RA2 = '0;
    #2;
    tick();
    CLR = 1'b1;
    settle();

    // Reset state: every address reads zero on both builds
    for (int a = 0; a < 8; a++) begin
      rd_both(a[2:0], a[2:0]);
      check_val($sformatf("rst_b_r%0d", a), rd1_b, 16'h0000);
      check_val($sformatf("rst_n_r%0d", a), rd2_n, 16'h0000);
    end

    // Reset mid-operation
    wr(3'd3, 16'h1234, 2'b11);
    rd_both(3'd3, 3'd3);
    check_val("pre_rst_r3", rd1_b, 16'h1234);
    CLR = 1'b0; WE = 1'b1; WA = 3'd3; WD = 16'hFFFF; BE = 2'b11;
    settle();
    check_val("rst_bypass_suppressed", rd1_b, 16'h1234);
    tick();
    CLR = 1'b1; WE = 1'b0;
    settle();
    check_val("post_rst_r3_b", rd1_b, 16'h0000);
    check_val("post_rst_r3_n", rd1_n, 16'h0000);

    // Enable gating
    CE = 1'b0; WE = 1'b1; WA = 3'd5; WD = 16'd60001; BE = 2'b11;
    rd_both(3'd5, 3'd5);
    check_val("ce0_bypass_suppressed", rd1_b, 16'h0000);
    tick();
    check_val("ce0_r5_unchanged", rd2_b, 16'h0000);
    CE = 1'b1;
    tick();
    WE = 1'b0;
    settle();
    check_val("ce1_r5_rd1", rd1_b, 16'd60001);
    check_val("ce1_r5_rd2", rd2_b, 16'd60001);
    check_val("ce1_r5_n", rd1_n, 16'd60001);

    // Byte enables
    wr(3'd2, 16'hABCD, 2'b11);
    wr(3'd2, 16'h1122, 2'b10);
    rd_both(3'd2, 3'd2);
    check_val("be_hi", rd1_b, 16'h11CD);
    wr(3'd2, 16'h3344, 2'b01);
    check_val("be_lo", rd1_b, 16'h1144);
    wr(3'd2, 16'hFFFF, 2'b00);
    check_val("be_none", rd1_b, 16'h1144);

    // Partial-byte bypass shows the merged word
    WE = 1'b1; WA = 3'd2; WD = 16'h9900; BE = 2'b10;
    settle();
    check_val("byp_merge", rd1_b, 16'h9944);
    check_val("nobyp_merge_old", rd1_n, 16'h1144);
    tick();
    WE = 1'b0;
    settle();
    check_val("merge_commit", rd1_n, 16'h9944);

    // Zero register
    WE = 1'b1; WA = 3'd0; WD = 16'd51234; BE = 2'b11;
    rd_both(3'd0, 3'd0);
    check_val("zero_during_b", rd1_b, 16'h0000);
    check_val("zero_during_n", rd1_n, 16'h0000);
    tick();
    WE = 1'b0;
    settle();
    check_val("zero_after_b", rd1_b, 16'h0000);
    check_val("zero_after_n", rd2_n, 16'h0000);

    // Bypass vs no bypass
    wr(3'd4, 16'd320, 2'b11);
    WE = 1'b1; WA = 3'd4; WD = 16'd51210; BE = 2'b11;
    rd_both(3'd4, 3'd4);
    check_val("byp_rd1", rd1_b, 16'd51210);
    check_val("byp_rd2", rd2_b, 16'd51210);
    check_val("nobyp_rd1_old", rd1_n, 16'd320);
    check_val("nobyp_rd2_old", rd2_n, 16'd320);
    tick();
    WE = 1'b0;
    settle();
    check_val("nobyp_rd1_new", rd1_n, 16'd51210);
    check_val("nobyp_rd2_new", rd2_n, 16'd51210);

    // Concurrent ports
    wr(3'd1, 16'd17, 2'b11);
    wr(3'd6, 16'd60001, 2'b11);
    WE = 1'b1; WA = 3'd6; WD = 16'd7; BE = 2'b11;
    rd_both(3'd1, 3'd6);
    check_val("conc_rd1", rd1_b, 16'd17);
    check_val("conc_rd2_byp", rd2_b, 16'd7);
    check_val("conc_rd2_nobyp", rd2_n, 16'd60001);
    tick();
    WE = 1'b0;
    settle();
    check_val("conc_rd2_after", rd2_b, 16'd7);
    check_val("conc_rd1_after", rd1_n, 16'd17);

    // Back-to-back writes to one address, last edge wins
    WE = 1'b1; WA = 3'd7; BE = 2'b11; WD = 16'hAAAA;
    tick();
    WD = 16'h5555;
    tick();
    WE = 1'b0;
    rd_both(3'd7, 3'd3);
    check_val("b2b_last", rd1_n, 16'h5555);
    check_val("b2b_other", rd2_n, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
